uart_tx: RTL and testbench

//  Downstream consumer of the single-entry fifo. Pops one WIDTH-bit word when the fifo is non-empty.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts clk cycles within one UART bit and pulses
// tick on the last cycle of the bit. Held at zero while clear is high so
// every frame starts on a fresh bit boundary.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Free-run 0..CLK_DIV-1 inside a frame, wrap at the bit end, park at 0 when cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (clear || (div_cnt == LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter fed from a single-entry fifo.
// Pops a word whenever idle and the fifo is non-empty, then sends start
// bit, data LSB first, optional even parity bit, and stop bit.
// Build option: define UART_TX_PARITY_EN to insert the even parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  uart_state_t      state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  logic             parity_reg;
`endif

  // The pop must coincide with the latch below: fifo data_out goes to 0 once emptied
  assign fifo_rd    = resetn && (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE);
  assign shift_next = shift_reg >> 1;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state == IDLE),
    .tick   (tick)
  );

  // Frame sequencer; tx is loaded with the next bit's level on the same edge the state changes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      tx        <= UART_IDLE_LEVEL;
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (!fifo_empty) begin
            shift_reg <= fifo_data;
            bit_cnt   <= '0;
            state     <= START;
            tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^fifo_data;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_next;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_reg;
`else
              state <= STOP;
              tx    <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= UART_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx    <= UART_IDLE_LEVEL;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with a behavioural single-entry fifo in front of it.
// A frame-level reference model predicts tx/busy/fifo_rd every cycle.
module tb_uart_tx;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int NBITS     = PARITY_ON ? 11 : 10;
  localparam int FRAME_CYC = NBITS * CLK_DIV;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd;
  logic             tx;
  logic             busy;

  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             f_full = 1'b0;
  logic [7:0]       f_mem = 8'h00;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int          m_left = 0;
  logic [10:0] m_bits = '1;
  int          m_pops = 0;
  logic        exp_rd;
  logic        exp_busy;
  logic        exp_tx;

  logic prev_tx = 1'b1;
  int   falls[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] time_order;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  uart_tx #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single-entry fifo; data_out reads 0 when empty
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_full <= 1'b0;
    end else begin
      if (fifo_rd) f_full <= 1'b0;
      if (wr_en && (!f_full || fifo_rd)) begin
        f_full <= 1'b1;
        f_mem  <= wr_data;
      end
    end
  end

  assign fifo_empty = !f_full;
  assign fifo_data  = f_full ? f_mem : 8'h00;

  // Reference model: a frame is a countdown over a precomputed bit vector
  assign exp_rd   = resetn && (m_left == 0) && !fifo_empty;
  assign exp_busy = (m_left > 0);
  assign exp_tx   = (m_left > 0) ? m_bits[(FRAME_CYC - m_left) / CLK_DIV] : 1'b1;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_left <= 0;
    end else if (exp_rd) begin
      m_left <= FRAME_CYC;
      m_bits <= PARITY_ON ? {1'b1, ^fifo_data, fifo_data, 1'b0}
                          : {1'b1, 1'b1, fifo_data, 1'b0};
      m_pops <= m_pops + 1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-by-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (tx !== exp_tx || busy !== exp_busy || fifo_rd !== exp_rd) begin
        n_err++;
        $display("[TB] FAIL model cyc=%0d tx=%b exp %b busy=%b exp %b rd=%b exp %b",
                 cyc, tx, exp_tx, busy, exp_busy, fifo_rd, exp_rd);
      end
    end
  end

  // Record start-bit falling edges for spacing checks
  always @(negedge clk) begin
    if (prev_tx && !tx) falls.push_back(cyc);
    prev_tx <= tx;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s got %b want %b (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s got %0d want %0d (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    int t = 0;
    @(posedge clk); #1;
    while (f_full && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (f_full) begin
      checkInt("write_wait_timeout", t, 0);
    end else begin
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      n_wr++;
    end
  endtask

  task automatic waitPop();
    int t = 0;
    @(negedge clk);
    while (!fifo_rd && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput("pop_seen", fifo_rd, 1'b1);
  endtask

  // Call at the negedge of the pop cycle; checks every bit mid-period and busy length
  task automatic checkFrame(input vec_t v);
    logic exp_bits[11];
    int   bcnt = 0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = v.time_order[7-i];
    exp_bits[9]  = PARITY_ON ? v.par : 1'b1;
    exp_bits[10] = 1'b1;
    for (int j = 1; j <= FRAME_CYC; j++) begin
      @(negedge clk);
      if (j == 1) checkOutput("rd_pulse_width", fifo_rd, 1'b0);
      if (busy) bcnt++;
      if (((j - 1) % CLK_DIV) == 1)
        checkOutput($sformatf("d%02h_bit%0d", v.data, (j - 1) / CLK_DIV), tx,
                    exp_bits[(j - 1) / CLK_DIV]);
    end
    @(negedge clk);
    checkOutput("busy_after_frame", busy, 1'b0);
    checkInt("busy_len", bcnt, FRAME_CYC);
  endtask

  initial begin
    int   viol;
    int   t;
    vec_t race_vec;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 8'hE0, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{8'h12, 8'h48, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1};
    vecs[6] = '{8'h3C, 8'h3C, 1'b0};
    race_vec = '{8'h12, 8'h48, 1'b0};

    $display("[TB] start, parity=%0d frame=%0d cycles", PARITY_ON, FRAME_CYC);

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rd", fifo_rd, 1'b0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Table vectors: single frames including the parity examples
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data);
      waitPop();
      checkFrame(vecs[i]);
    end

    // Long idle with an empty fifo
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd !== 1'b0) viol++;
    end
    checkInt("idle_200", viol, 0);

    // Back-to-back frames: start bits exactly one frame plus the pop cycle apart
    falls.delete();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    t = 0;
    while (falls.size() < 2 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (falls.size() >= 2) checkInt("b2b_spacing", falls[1] - falls[0], FRAME_CYC + 1);
    else checkInt("b2b_falls", falls.size(), 2);
    repeat (FRAME_CYC + 4) @(negedge clk);

    // Refill race: write lands on the edge that returns the transmitter to idle
    applyStimulus(8'hC3);
    waitPop();
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_data = race_vec.data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    n_wr++;
    @(negedge clk);
    checkOutput("race_pop", fifo_rd, 1'b1);
    checkOutput("race_idle", busy, 1'b0);
    checkFrame(race_vec);

    // Reset in the middle of data bit 3
    applyStimulus(8'h3C);
    waitPop();
    repeat (18) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_reset_tx", tx, 1'b1);
    checkOutput("async_reset_busy", busy, 1'b0);
    checkOutput("async_reset_rd", fifo_rd, 1'b0);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    checkInt("post_reset_quiet", viol, 0);

    // Random traffic with random gaps, checked by the model every cycle
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 50)) @(posedge clk);
      applyStimulus(8'($urandom));
    end
    t = 0;
    @(negedge clk);
    while ((m_left != 0 || f_full) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    checkInt("drained", (m_left == 0 && !f_full) ? 1 : 0, 1);
    checkInt("no_loss", m_pops, n_wr);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
